// File: rtl/operand_fetch_stage_pkg.sv
// CMP ISA definitions shared by the ID stage: opcodes, instruction field positions,
// ppp lane-select encodings and the ID/EX pipeline register layout.
package cmp_isa_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef enum logic [5:0] {
    OP_VLD   = 6'b100000,
    OP_VSD   = 6'b100001,
    OP_VBEZ  = 6'b100010,
    OP_VBNEZ = 6'b100011,
    OP_RTYPE = 6'b101010,
    OP_NOP   = 6'b111100
  } opcode_e;

  typedef enum logic [2:0] {
    PPP_ALL   = 3'b000,
    PPP_UPPER = 3'b001,
    PPP_LOWER = 3'b010,
    PPP_EVEN  = 3'b011,
    PPP_ODD   = 3'b100
  } ppp_e;

  // Fields are documented MSB-first (bit 0 = MSB); these are the LSB-0 slice bounds.
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 26;
  localparam int unsigned RD_MSB   = 25;
  localparam int unsigned RD_LSB   = 21;
  localparam int unsigned RA_MSB   = 20;
  localparam int unsigned RA_LSB   = 16;
  localparam int unsigned RB_MSB   = 15;
  localparam int unsigned RB_LSB   = 11;
  localparam int unsigned PPP_MSB  = 10;
  localparam int unsigned PPP_LSB  = 8;
  localparam int unsigned WW_MSB   = 7;
  localparam int unsigned WW_LSB   = 6;
  localparam int unsigned FUNC_MSB = 5;
  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] rd;
    ppp_e                  ppp;
    logic [1:0]            ww;
    logic [5:0]            func;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
  } idex_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// ID-stage bus bundle: IF/ID input, register-file read ports, EX/MEM writer info and ID/EX outputs.
// slave = the ID stage, master = the surrounding pipeline.
interface operand_fetch_stage_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 16
);
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic                   stall_in;
  logic                   exmem_we;
  logic [ADDR_WIDTH-1:0]  exmem_rd;
  logic [ADDR_WIDTH-1:0]  rf_addr_rd_0;
  logic [ADDR_WIDTH-1:0]  rf_addr_rd_1;
  logic [DATA_WIDTH-1:0]  rf_data_0;
  logic [DATA_WIDTH-1:0]  rf_data_1;
  logic                   stall_out;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   ex_valid;
  logic                   ex_we;
  logic                   ex_mem_rd;
  logic                   ex_mem_wr;
  logic [ADDR_WIDTH-1:0]  ex_rd;
  logic [2:0]             ex_ppp;
  logic [1:0]             ex_ww;
  logic [5:0]             ex_func;
  logic [15:0]            ex_imm;
  logic [DATA_WIDTH-1:0]  ex_op_a;
  logic [DATA_WIDTH-1:0]  ex_op_b;

  modport slave (
    input  if_valid, if_instr, stall_in, exmem_we, exmem_rd, rf_data_0, rf_data_1,
    output rf_addr_rd_0, rf_addr_rd_1, stall_out, branch_taken, branch_target,
           ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_rd, ex_ppp, ex_ww, ex_func,
           ex_imm, ex_op_a, ex_op_b
  );

  modport master (
    output if_valid, if_instr, stall_in, exmem_we, exmem_rd, rf_data_0, rf_data_1,
    input  rf_addr_rd_0, rf_addr_rd_1, stall_out, branch_taken, branch_target,
           ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_rd, ex_ppp, ex_ww, ex_func,
           ex_imm, ex_op_a, ex_op_b
  );
endinterface

// File: rtl/operand_fetch_stage_hazard_unit.sv
// RAW hazard detect: a used source matching an in-flight writer in EX or MEM.
// WB is covered by register-file internal forwarding, so it is not checked here.
module hazard_unit #(
  parameter int unsigned ADDR_WIDTH = cmp_isa_pkg::ADDR_WIDTH
) (
  input  logic                  valid_i,
  input  logic                  use0_i,
  input  logic                  use1_i,
  input  logic [ADDR_WIDTH-1:0] src0_i,
  input  logic [ADDR_WIDTH-1:0] src1_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                  exmem_we_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  output logic                  hazard_o
);
  import cmp_isa_pkg::*;

  logic ex_wr, hit0, hit1;

  always_comb begin
    ex_wr    = ex_valid_i & ex_we_i;
    hit0     = (ex_wr & (src0_i == ex_rd_i)) | (exmem_we_i & (src0_i == exmem_rd_i));
    hit1     = (ex_wr & (src1_i == ex_rd_i)) | (exmem_we_i & (src1_i == exmem_rd_i));
    hazard_o = valid_i & ((use0_i & hit0) | (use1_i & hit1));
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: RF read addressing, RAW stall, ID-resolved branches, ID/EX register.
// Optional OPERAND_FETCH_STALL_CNT_EN adds a saturating hazard-stall counter output.
module operand_fetch_stage #(
  parameter int unsigned DATA_WIDTH  = cmp_isa_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = cmp_isa_pkg::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  operand_fetch_stage_if.slave bus
`ifdef OPERAND_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);
  import cmp_isa_pkg::*;

  logic [INSTR_WIDTH-1:0] instr;
  logic [5:0]             opc;
  logic [ADDR_WIDTH-1:0]  f_rd, f_ra, f_rb;
  logic [DATA_WIDTH-1:0]  data0;
  logic use0, use1, dec_we, dec_mrd, dec_mwr, is_bez, is_bnez, src0_is_rd;
  logic hazard;
  idex_t idex_q, idex_d;

  assign instr = bus.if_instr;
  assign data0 = bus.rf_data_0;

  always_comb begin
    opc        = instr[OPC_MSB:OPC_LSB];
    f_rd       = instr[RD_MSB:RD_LSB];
    f_ra       = instr[RA_MSB:RA_LSB];
    f_rb       = instr[RB_MSB:RB_LSB];
    use0       = 1'b0;
    use1       = 1'b0;
    dec_we     = 1'b0;
    dec_mrd    = 1'b0;
    dec_mwr    = 1'b0;
    is_bez     = 1'b0;
    is_bnez    = 1'b0;
    src0_is_rd = 1'b0;
    case (opc)
      OP_RTYPE: begin use0 = 1'b1; use1 = 1'b1; dec_we = 1'b1; end
      OP_VLD:   begin dec_we = 1'b1; dec_mrd = 1'b1; end
      OP_VSD:   begin use0 = 1'b1; src0_is_rd = 1'b1; dec_mwr = 1'b1; end
      OP_VBEZ:  begin use0 = 1'b1; src0_is_rd = 1'b1; is_bez = 1'b1; end
      OP_VBNEZ: begin use0 = 1'b1; src0_is_rd = 1'b1; is_bnez = 1'b1; end
      default:  ;
    endcase
  end

  assign bus.rf_addr_rd_0 = src0_is_rd ? f_rd : f_ra;
  assign bus.rf_addr_rd_1 = f_rb;

  hazard_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
    .valid_i    (bus.if_valid),
    .use0_i     (use0),
    .use1_i     (use1),
    .src0_i     (bus.rf_addr_rd_0),
    .src1_i     (bus.rf_addr_rd_1),
    .ex_valid_i (idex_q.valid),
    .ex_we_i    (idex_q.we),
    .ex_rd_i    (idex_q.rd),
    .exmem_we_i (bus.exmem_we),
    .exmem_rd_i (bus.exmem_rd),
    .hazard_o   (hazard)
  );

  assign bus.stall_out     = hazard | bus.stall_in;
  assign bus.branch_taken  = bus.if_valid & ~bus.stall_out &
                             ((is_bez & (data0 == '0)) | (is_bnez & (data0 != '0)));
  assign bus.branch_target = PC_WIDTH'(instr[IMM_MSB:IMM_LSB]);

  // Branches always leave a bubble whether taken or not; their work is done in ID.
  always_comb begin
    idex_d = idex_q;
    if (!bus.stall_in) begin
      if (hazard || is_bez || is_bnez || !bus.if_valid) begin
        idex_d = '0;
      end else begin
        idex_d.valid  = 1'b1;
        idex_d.we     = dec_we;
        idex_d.mem_rd = dec_mrd;
        idex_d.mem_wr = dec_mwr;
        idex_d.rd     = f_rd;
        idex_d.ppp    = ppp_e'(instr[PPP_MSB:PPP_LSB]);
        idex_d.ww     = instr[WW_MSB:WW_LSB];
        idex_d.func   = instr[FUNC_MSB:FUNC_LSB];
        idex_d.imm    = instr[IMM_MSB:IMM_LSB];
        idex_d.op_a   = bus.rf_data_0;
        idex_d.op_b   = bus.rf_data_1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign bus.ex_valid  = idex_q.valid;
  assign bus.ex_we     = idex_q.we;
  assign bus.ex_mem_rd = idex_q.mem_rd;
  assign bus.ex_mem_wr = idex_q.mem_wr;
  assign bus.ex_rd     = idex_q.rd;
  assign bus.ex_ppp    = idex_q.ppp;
  assign bus.ex_ww     = idex_q.ww;
  assign bus.ex_func   = idex_q.func;
  assign bus.ex_imm    = idex_q.imm;
  assign bus.ex_op_a   = idex_q.op_a;
  assign bus.ex_op_b   = idex_q.op_b;

`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !bus.stall_in && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch (ID) stage of each CMP core pipeline.
- Drives the two register_file read addresses and captures the returned operands into the ID/EX pipeline register.
- Detects RAW hazards against in-flight writers and stalls, because the register file only covers the WB stage through internal forwarding.
- Resolves VBEZ/VBNEZ branches in ID and flushes the IF/ID slot.

Parameters:
- DATA_WIDTH, 64, register/operand width.
- ADDR_WIDTH, 5, register index width.
- INSTR_WIDTH, 32, instruction width.
- PC_WIDTH, 16, instruction-memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  32  instruction. Bit 0 is MSB. Fields: opcode[0:5], rD[6:10], rA[11:15], rB[16:20], ppp[21:23], ww[24:25], func[26:31], imm[16:31].
- stall_in  in  1  downstream (memory/NIC) freeze.
- exmem_we  in  1  EX/MEM instruction writes the RF.
- exmem_rd  in  5  EX/MEM destination register.
- rf_addr_rd_0  out  5  read port 0 address (comb.).
- rf_addr_rd_1  out  5  read port 1 address (comb.).
- rf_data_0  in  64  read port 0 data.
- rf_data_1  in  64  read port 1 data.
- stall_out  out  1  hold PC and IF/ID (comb.).
- branch_taken  out  1  one-cycle redirect.
- branch_target  out  16  equals imm.
- ex_valid, ex_we, ex_mem_rd, ex_mem_wr  out  1 each  ID/EX control.
- ex_rd  out  5  ID/EX destination register.
- ex_ppp  out  3  ID/EX ppp field.
- ex_ww  out  2  ID/EX ww field.
- ex_func  out  6  ID/EX func field.
- ex_imm  out  16  ID/EX immediate.
- ex_op_a, ex_op_b  out  64 each  ID/EX operands.

Behaviour:
- Opcodes: R-type 101010, VLD 100000, VSD 100001, VBEZ 100010, VBNEZ 100011, NOP 111100. Any other opcode is treated as NOP.
- Read port 0 address: rD for VSD/VBEZ/VBNEZ, rA otherwise. Read port 1 address: rB. Both are combinational from if_instr.
- Source usage:
  - R-type uses port 0 and port 1.
  - VSD/VBEZ/VBNEZ use port 0 only.
  - VLD/NOP use no sources.
- Writers: R-type and VLD (we=1). VLD also sets mem_rd=1; VSD sets mem_wr=1.
- Hazard: if_valid and a used source equals ex_rd with ex_valid&ex_we, or equals exmem_rd with exmem_we.
  - stall_out = hazard | stall_in.
- ID/EX register, on every clk edge:
  - stall_in=1: hold all ID/EX contents.
  - Otherwise, if hazard, branch, or !if_valid: load a bubble (valid/we/mem_rd/mem_wr = 0; data fields are don't-care but driven to 0).
  - Otherwise: latch the decoded fields plus ex_op_a=rf_data_0 and ex_op_b=rf_data_1.
- Latency: 1 cycle from IF/ID to ID/EX when there is no hazard. A dependent instruction waits until its producer reaches WB (at most 2 stall cycles).
- Branch, combinational:
  - branch_taken = if_valid & !stall_out & ((VBEZ & rf_data_0==0) | (VBNEZ & rf_data_0!=0)).
  - The IF stage squashes its next instruction when branch_taken=1.
  - A branch waiting on a hazard never asserts branch_taken.
  - Branch instructions enter ID/EX as bubbles.
- Simultaneous hazard and stall_in: stall_in dominates and ID/EX holds.
- Reset (asynchronous): all ID/EX outputs go to 0, so ex_valid=0. Combinational outputs follow their inputs. Reset asserted mid-stall clears ID/EX immediately.

Optional Feature:
- Macro: OPERAND_FETCH_STALL_CNT_EN.
- With the macro defined:
  - Extra output stall_count, 32 bits.
  - Increments on each clk edge where hazard=1 and stall_in=0.
  - Saturates at 0xFFFF_FFFF.
  - Reset value 0.
- Without it: the port and counter are absent.

Decomposition:
- Package cmp_isa_pkg holds:
  - opcode constants;
  - instruction field bit positions;
  - ppp encodings (000 all, 001 upper, 010 lower, 011 even, 100 odd);
  - DATA_WIDTH and ADDR_WIDTH constants.
- Sub-module hazard_unit: purely combinational. Inputs are source usage, addresses, and ex/exmem writer info; output is hazard.

Test Plan:
- R-type rD=3, rA=1, rB=2, with RF $1=0x5, $2=0x7 → next cycle ex_valid=1, ex_op_a=0x5, ex_op_b=0x7, ex_rd=3, stall_out=0.
- VLD rD=4, then R-type using rA=4 → stall_out=1 for 2 cycles with bubbles in ID/EX, then issue with the value written by WB.
- VBEZ rD=6 with $6=0, imm=0x0040 → branch_taken=1 for one cycle, branch_target=0x0040, ex_valid=0 next cycle. With $6=1 → branch_taken=0.
- stall_in=1 for 3 cycles during a valid issue → ID/EX contents unchanged and stall_out=1 throughout.
- reset asserted asynchronously mid-cycle while ex_valid=1 → ex_valid and all ex_* outputs read 0 before the next clk edge.
- With OPERAND_FETCH_STALL_CNT_EN: the VLD-use sequence run twice → stall_count=4.
